// File: rtl/ddr_img_pkg.sv
// ddr_img_pkg: shared constants, state encoding and frame-size helper for the
// image write path feeding the ib1 DDR3 FIFO.
//   PIX_W / WORD_W / LANES : beat width, FIFO word width, beats per word
//   IMG_COL/CH/TAP/BYTE    : fixed sensor geometry (rows come in at run time)
//   state_t                : packer FSM states
//   frame_beats()          : 32-bit beats per frame for a given row count
package ddr_img_pkg;

  localparam int PIX_W    = 32;
  localparam int WORD_W   = 256;
  localparam int LANES    = WORD_W / PIX_W;
  localparam int LANE_W   = $clog2(LANES);

  localparam int IMG_COL  = 43;
  localparam int IMG_CH   = 6;
  localparam int IMG_TAP  = 2;
  localparam int IMG_BYTE = 2;

  // 32-bit beats contributed by one image row (43*6*2*2/4 = 258).
  localparam logic [31:0] ROW_BEATS = 32'(IMG_COL * IMG_CH * IMG_TAP * IMG_BYTE / 4);

  typedef enum logic [1:0] {
    S_WAIT_SOF = 2'd0,
    S_PACK     = 2'd1,
    S_DROP     = 2'd2
  } state_t;

  // Beats per frame, modulo 2^32.
  function automatic logic [31:0] frame_beats(input logic [31:0] img_row);
    return img_row * ROW_BEATS;
  endfunction

endpackage

// File: rtl/lane_shift_reg.sv
// lane_shift_reg: 8 x 32-bit lane register that accumulates beats of one
// 256-bit word.
//   clk, reset : clock, synchronous active-high reset
//   store      : write data into lane `lane`
//   restart    : start a new word: lane 0 = data, all other lanes cleared
//   flush      : clear all lanes (word has been handed off)
//   lane, data : target lane and beat data
//   word       : current lanes with lane `lane` replaced by `data`, i.e. the
//                word as it looks once the current beat is included
// Lanes are always zero between words, so a partial final word comes out
// zero-padded in its upper lanes without extra logic.
module lane_shift_reg
  import ddr_img_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              store,
  input  logic              restart,
  input  logic              flush,
  input  logic [LANE_W-1:0] lane,
  input  logic [PIX_W-1:0]  data,
  output logic [WORD_W-1:0] word
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [PIX_W-1:0] lane_reg;

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          lane_reg <= '0;
        end else if (restart) begin
          lane_reg <= (gi == 0) ? data : '0;
        end else if (store && lane == LANE_W'(gi)) begin
          lane_reg <= data;
        end
      end

      assign word[gi*PIX_W +: PIX_W] = (lane == LANE_W'(gi)) ? data : lane_reg;
    end
  endgenerate

endmodule

// File: rtl/img_pack_256.sv
// img_pack_256: packs 32-bit sensor beats into 256-bit words for the ib1
// FIFO, frame aware (beat counting, zero-padded last word, drop on overflow,
// short-frame detection) with per-frame host status.
//   clk, reset            : clock, synchronous active-high reset
//   en                    : packing enable, only looked at while waiting for SOF
//   IMG_ROW               : rows per frame, captured with an accepted SOF
//   pix_valid/sof/data    : input beat stream (cannot be stalled)
//   fifo_full             : ib1 FIFO full, checked only when a word completes
//   fifo_we, fifo_data    : FIFO write, one cycle after the completing beat
//   frame_done            : pulse the cycle after a frame's last write
//   frame_cnt             : completed frames (counts on the frame_done cycle)
//   ovf_err, short_err    : sticky status
//   clr_status            : clears frame_cnt and both errors (sets win)
module img_pack_256
  import ddr_img_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [31:0]       IMG_ROW,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              fifo_full,
  output logic              fifo_we,
  output logic [WORD_W-1:0] fifo_data,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              ovf_err,
  output logic              short_err,
  input  logic              clr_status
);

  state_t              state_reg;
  logic [LANE_W-1:0]   lane_reg;
  logic [31:0]         count_reg;
  logic [31:0]         frame_beats_reg;
  logic                done_pending_reg;
  logic                fifo_we_reg;
  logic [WORD_W-1:0]   fifo_data_reg;
  logic                frame_done_reg;
  logic [15:0]         frame_cnt_reg;
  logic                ovf_err_reg;
  logic                short_err_reg;

  logic                sof_beat;
  logic                row_is_zero;
  logic                start_frame;
  logic                pack_beat;
  logic                last_beat;
  logic                word_done;
  logic                single_beat;
  logic                completion;
  logic                frame_end;
  logic                lane_store;
  logic                lane_restart;
  logic                lane_flush;
  logic [WORD_W-1:0]   packed_word;
  logic [WORD_W-1:0]   comp_word;

  assign sof_beat    = pix_valid & pix_sof;
  // 258 = 2*129 with 129 odd, so row*258 wraps to 0 exactly when the low 31
  // row bits are zero. In that case the SOF beat is the whole frame; this is
  // decided straight from the input because the product is not yet registered.
  assign row_is_zero = (IMG_ROW[30:0] == '0);

  // An SOF restarts a frame from any state; only the idle state honours en.
  assign start_frame = sof_beat & ((state_reg == S_WAIT_SOF & en) |
                                   (state_reg == S_DROP) |
                                   (state_reg == S_PACK));
  assign pack_beat   = (state_reg == S_PACK) & pix_valid & ~pix_sof;
  assign last_beat   = (count_reg + 32'd1 == frame_beats_reg);
  assign word_done   = pack_beat & ((lane_reg == LANE_W'(LANES - 1)) | last_beat);
  assign single_beat = start_frame & row_is_zero;
  assign completion  = word_done | single_beat;
  assign frame_end   = (word_done & last_beat) | single_beat;

  assign lane_store   = pack_beat & ~word_done;
  assign lane_restart = start_frame & ~row_is_zero;
  assign lane_flush   = completion;

  lane_shift_reg u_lanes (
    .clk     (clk),
    .reset   (reset),
    .store   (lane_store),
    .restart (lane_restart),
    .flush   (lane_flush),
    .lane    (lane_reg),
    .data    (pix_data),
    .word    (packed_word)
  );

  // A single-beat frame may arrive mid-frame while the lanes still hold stale
  // data, so its word is built directly from the beat.
  assign comp_word = single_beat ? WORD_W'(pix_data) : packed_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= S_WAIT_SOF;
      lane_reg         <= '0;
      count_reg        <= '0;
      frame_beats_reg  <= '0;
      done_pending_reg <= 1'b0;
      fifo_we_reg      <= 1'b0;
      fifo_data_reg    <= '0;
      frame_done_reg   <= 1'b0;
      frame_cnt_reg    <= '0;
      ovf_err_reg      <= 1'b0;
      short_err_reg    <= 1'b0;
    end else begin
      fifo_we_reg      <= 1'b0;
      done_pending_reg <= 1'b0;
      frame_done_reg   <= done_pending_reg;

      // The count advances on the cycle frame_done is high, so a clear in
      // that same cycle leaves exactly this frame counted.
      frame_cnt_reg <= clr_status ? 16'(frame_done_reg)
                                  : frame_cnt_reg + 16'(frame_done_reg);

      if (completion && fifo_full) begin
        ovf_err_reg <= 1'b1;
      end else if (clr_status) begin
        ovf_err_reg <= 1'b0;
      end

      if (start_frame && state_reg == S_PACK) begin
        short_err_reg <= 1'b1;
      end else if (clr_status) begin
        short_err_reg <= 1'b0;
      end

      if (start_frame) begin
        frame_beats_reg <= frame_beats(IMG_ROW);
        lane_reg        <= LANE_W'(1);
        count_reg       <= 32'd1;
      end else if (pack_beat) begin
        lane_reg  <= lane_reg + LANE_W'(1);
        count_reg <= count_reg + 32'd1;
      end

      if (completion && !fifo_full) begin
        fifo_we_reg   <= 1'b1;
        fifo_data_reg <= comp_word;
      end
      if (frame_end && !fifo_full) begin
        done_pending_reg <= 1'b1;
      end

      if (completion && fifo_full) begin
        state_reg <= S_DROP;
      end else if (frame_end) begin
        state_reg <= S_WAIT_SOF;
      end else if (start_frame) begin
        state_reg <= S_PACK;
      end
    end
  end

  assign fifo_we    = fifo_we_reg;
  assign fifo_data  = fifo_data_reg;
  assign frame_done = frame_done_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign ovf_err    = ovf_err_reg;
  assign short_err  = short_err_reg;

endmodule
